// File: rtl/ddr_rw_scheduler.sv
// ddr_rw_scheduler
//   Shares the single command port of the DDR3 AXI master between the write
//   and read channel arbiters. Bursts are serialised. Same-direction streaks
//   are preferred, but capped so that the other direction cannot starve. A
//   turnaround gap is inserted on every direction change, and a watchdog
//   aborts a burst that never completes.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   wr_req/wr_addr/wr_len  : write arbiter request, held stable until wr_ack
//   wr_ack, wr_done        : 1-cycle pulses on write issue / write finish
//   rd_req/rd_addr/rd_len  : read arbiter request, held stable until rd_ack
//   rd_ack, rd_done        : 1-cycle pulses on read issue / read finish
//   mem_start              : 1-cycle command strobe to the AXI master
//   mem_wr/mem_addr/mem_len: registered command, held until the next issue
//   mem_done               : burst-complete pulse from the AXI master
//   timeout_err            : sticky watchdog abort flag, cleared by rst
module ddr_rw_scheduler #(
    parameter int MAX_STREAK = 4,
    parameter int TURN_CYC   = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic [29:0] wr_addr,
    input  logic [7:0]  wr_len,
    output logic        wr_ack,
    output logic        wr_done,
    input  logic        rd_req,
    input  logic [29:0] rd_addr,
    input  logic [7:0]  rd_len,
    output logic        rd_ack,
    output logic        rd_done,
    output logic        mem_start,
    output logic        mem_wr,
    output logic [29:0] mem_addr,
    output logic [7:0]  mem_len,
    input  logic        mem_done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, TURN, ISSUE, BUSY} state_t;
    typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} dir_t;

    localparam logic [3:0]  STREAK_CAP = 4'(MAX_STREAK);
    localparam logic [3:0]  TURN_LOAD  = 4'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
    localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT);
    localparam bit          HAS_TURN   = (TURN_CYC > 0);

    state_t      state;
    dir_t        sel_dir;
    dir_t        last_dir;
    logic [29:0] sel_addr;
    logic [7:0]  sel_len;
    logic [3:0]  streak;
    logic [3:0]  turn_cnt;
    logic [15:0] wd_cnt;

    dir_t        pick_dir;
    logic [29:0] pick_addr;
    logic [7:0]  pick_len;
    logic        need_turn;
    logic        go_issue;
    dir_t        issue_dir;
    logic [29:0] issue_addr;
    logic [7:0]  issue_len;

    // Direction choice in IDLE: a lone request wins outright; with both
    // pending, stay on last_dir until the streak cap is hit.
    always_comb begin
        pick_dir = last_dir;
        if (wr_req && !rd_req) begin
            pick_dir = DIR_WR;
        end else if (rd_req && !wr_req) begin
            pick_dir = DIR_RD;
        end else if (streak >= STREAK_CAP) begin
            pick_dir = (last_dir == DIR_WR) ? DIR_RD : DIR_WR;
        end
        pick_addr = (pick_dir == DIR_WR) ? wr_addr : rd_addr;
        pick_len  = (pick_dir == DIR_WR) ? wr_len  : rd_len;
        need_turn = HAS_TURN && (pick_dir != last_dir);
    end

    // Outputs are registered, so the command is loaded on the edge that
    // enters ISSUE: straight from IDLE, or at the end of the turnaround.
    always_comb begin
        go_issue   = 1'b0;
        issue_dir  = sel_dir;
        issue_addr = sel_addr;
        issue_len  = sel_len;
        if (state == IDLE && (wr_req || rd_req) && !need_turn) begin
            go_issue   = 1'b1;
            issue_dir  = pick_dir;
            issue_addr = pick_addr;
            issue_len  = pick_len;
        end else if (state == TURN && turn_cnt == 4'd0) begin
            go_issue = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel_dir     <= DIR_WR;
            last_dir    <= DIR_WR;
            sel_addr    <= '0;
            sel_len     <= '0;
            streak      <= '0;
            turn_cnt    <= '0;
            wd_cnt      <= '0;
            wr_ack      <= 1'b0;
            rd_ack      <= 1'b0;
            wr_done     <= 1'b0;
            rd_done     <= 1'b0;
            mem_start   <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_len     <= '0;
            timeout_err <= 1'b0;
        end else begin
            mem_start <= 1'b0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;

            if (go_issue) begin
                mem_start <= 1'b1;
                mem_wr    <= (issue_dir == DIR_WR);
                mem_addr  <= issue_addr;
                mem_len   <= issue_len;
                wr_ack    <= (issue_dir == DIR_WR);
                rd_ack    <= (issue_dir == DIR_RD);
            end

            case (state)
                IDLE: begin
                    if (wr_req || rd_req) begin
                        sel_dir  <= pick_dir;
                        sel_addr <= pick_addr;
                        sel_len  <= pick_len;
                        if (need_turn) begin
                            turn_cnt <= TURN_LOAD;
                            state    <= TURN;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                TURN: begin
                    if (turn_cnt == 4'd0) begin
                        state <= ISSUE;
                    end else begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end
                end
                ISSUE: begin
                    last_dir <= sel_dir;
                    if (sel_dir == last_dir) begin
                        streak <= (streak == 4'd15) ? 4'd15 : streak + 4'd1;
                    end else begin
                        streak <= 4'd1;
                    end
                    wd_cnt <= '0;
                    state  <= BUSY;
                end
                BUSY: begin
                    // mem_done takes priority over a watchdog expiring in the same cycle
                    if (mem_done) begin
                        wr_done <= (sel_dir == DIR_WR);
                        rd_done <= (sel_dir == DIR_RD);
                        state   <= IDLE;
                    end else if (wd_cnt + 16'd1 == WD_LIMIT) begin
                        wr_done     <= (sel_dir == DIR_WR);
                        rd_done     <= (sel_dir == DIR_RD);
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rw_scheduler.sv
// Self-checking bench for ddr_rw_scheduler. A transaction-level model keeps
// the history of issued directions and derives the arbitration choice, the
// issue latency and the done/timeout outcome of each burst from it.
module tb_ddr_rw_scheduler;

    localparam int MAX_STREAK = 4;
    localparam int TURN_CYC   = 2;
    localparam int TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [29:0] wr_addr;
    logic [7:0]  wr_len;
    logic        wr_ack;
    logic        wr_done;
    logic        rd_req;
    logic [29:0] rd_addr;
    logic [7:0]  rd_len;
    logic        rd_ack;
    logic        rd_done;
    logic        mem_start;
    logic        mem_wr;
    logic [29:0] mem_addr;
    logic [7:0]  mem_len;
    logic        mem_done;
    logic        timeout_err;

    always #5 clk = ~clk;

    ddr_rw_scheduler #(
        .MAX_STREAK(MAX_STREAK),
        .TURN_CYC  (TURN_CYC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_len     (wr_len),
        .wr_ack     (wr_ack),
        .wr_done    (wr_done),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_len     (rd_len),
        .rd_ack     (rd_ack),
        .rd_done    (rd_done),
        .mem_start  (mem_start),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_len    (mem_len),
        .mem_done   (mem_done),
        .timeout_err(timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: every issued direction (1 = write) and the sticky error.
    bit hist[$];
    bit model_err = 1'b0;
    bit streak_seq[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_last();
        return (hist.size() == 0) ? 1'b1 : hist[hist.size() - 1];
    endfunction

    function automatic int model_streak();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != model_last()) break;
            n++;
        end
        return (n > 15) ? 15 : n;
    endfunction

    // Starts at a negedge with the DUT idle; ends at the negedge of the
    // done-pulse cycle (DUT idle again). d = BUSY cycle carrying mem_done
    // (1 = first cycle after issue), 0 = never.
    task automatic do_round(input bit w, input bit r,
                            input logic [29:0] wa, input logic [7:0] wl,
                            input logic [29:0] ra, input logic [7:0] rl,
                            input int d, output bit obs_wr);
        bit dir;
        bit turn;
        bit exp_to;
        int lat;
        int end_c;
        wr_req  = w;
        rd_req  = r;
        wr_addr = wa;
        wr_len  = wl;
        rd_addr = ra;
        rd_len  = rl;
        mem_done = 1'b0;
        if (w && r) dir = (model_streak() < MAX_STREAK) ? model_last() : !model_last();
        else        dir = w;
        turn = (dir != model_last()) && (TURN_CYC > 0);
        lat  = turn ? 1 + TURN_CYC : 1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                check("turn_gap_quiet", {mem_start, wr_ack, rd_ack}, 0);
                // requester may give up after selection; issue must still happen
                if ($urandom_range(1, 0) == 1) begin
                    wr_req = 1'b0;
                    rd_req = 1'b0;
                end
            end
        end
        obs_wr = mem_wr;
        check("issue_start", mem_start, 1);
        check("issue_dir", mem_wr, dir);
        check("issue_addr", mem_addr, dir ? wa : ra);
        check("issue_len", mem_len, dir ? wl : rl);
        check("issue_acks", {wr_ack, rd_ack}, {dir, !dir});
        hist.push_back(dir);
        if ($urandom_range(1, 0) == 1) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        exp_to = !(d != 0 && d <= TIMEOUT);
        end_c  = exp_to ? TIMEOUT + 1 : d + 1;
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            if (c < end_c) begin
                check("busy_quiet", {mem_start, wr_ack, rd_ack, wr_done, rd_done}, 0);
                mem_done = (c == d);
            end
        end
        mem_done = 1'b0;
        if (exp_to) model_err = 1'b1;
        check("done_pulse", {wr_done, rd_done}, {dir, !dir});
        check("timeout_err", timeout_err, model_err);
        check("hold_cmd", {mem_wr, mem_addr, mem_len}, {dir, dir ? wa : ra, dir ? wl : rl});
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            mem_done = stray && (i % 2 == 0);
            @(negedge clk);
            check("idle_quiet", {mem_start, wr_ack, rd_ack, wr_done, rd_done}, 0);
            check("idle_err", timeout_err, model_err);
        end
        mem_done = 1'b0;
    endtask

    initial begin
        bit obs;
        int d;
        bit w;
        bit r;

        rst      = 1'b1;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        wr_addr  = '0;
        wr_len   = '0;
        rd_addr  = '0;
        rd_len   = '0;
        mem_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {mem_start, mem_wr, mem_addr, mem_len, wr_ack, rd_ack,
                                wr_done, rd_done, timeout_err}, 0);
        rst = 1'b0;

        // Streak cap with both directions continuously requesting
        for (int i = 0; i < 9; i++) begin
            do_round(1'b1, 1'b1, 30'($urandom), 8'($urandom), 30'($urandom), 8'($urandom), 5, obs);
            check("streak_seq", obs, streak_seq[i]);
        end

        // Single write with fixed command
        do_round(1'b1, 1'b0, 30'h100, 8'd15, 30'h0, 8'd0, 12, obs);

        // Stray mem_done while idle
        idle_cycles(6, 1'b1);

        // mem_done coincident with watchdog expiry: normal completion
        do_round(1'b0, 1'b1, 30'h0, 8'd0, 30'h2A5, 8'd3, TIMEOUT, obs);

        // Watchdog abort, then a normal write
        do_round(1'b0, 1'b1, 30'h0, 8'd0, 30'h3C0, 8'd7, 0, obs);
        idle_cycles(3, 1'b0);
        do_round(1'b1, 1'b0, 30'h1234, 8'd1, 30'h0, 8'd0, 7, obs);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(1, 0));
            r = 1'($urandom_range(1, 0));
            d = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(20, 1));
            if (!w && !r) idle_cycles(2, 1'($urandom_range(1, 0)));
            else do_round(w, r, 30'($urandom), 8'($urandom), 30'($urandom), 8'($urandom), d, obs);
        end

        // Build a write streak at the cap, then reset in the middle of a write
        for (int i = 0; i < 3; i++) begin
            do_round(1'b1, 1'b0, 30'($urandom), 8'($urandom), 30'h0, 8'd0, 3, obs);
        end
        wr_req  = 1'b1;
        wr_addr = 30'h0ABC;
        wr_len  = 8'd9;
        @(negedge clk);
        check("rst_burst_issue", {mem_start, mem_wr, wr_ack}, 3'b111);
        wr_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_midburst_outputs", {mem_start, mem_wr, mem_addr, mem_len, wr_ack, rd_ack,
                                       wr_done, rd_done, timeout_err}, 0);
        rst = 1'b0;
        hist.delete();
        model_err = 1'b0;
        idle_cycles(4, 1'b0);
        do_round(1'b1, 1'b1, 30'h777, 8'd2, 30'h555, 8'd4, 4, obs);
        check("post_reset_first_dir", obs, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_rw_scheduler.md
Name: ddr_rw_scheduler

Overview:
- Shares the single command port of the DDR3 AXI master between the multichannel write arbiter and the multichannel read arbiter.
- Serialises bursts and favours same-direction streaks for bus efficiency, with a hard cap so neither direction starves.
- Inserts a programmable turnaround gap on every direction change.
- Sits between the two channel arbiters and the AXI master; flags a stuck burst via a watchdog.

Parameters:
- MAX_STREAK, 4, max consecutive same-direction bursts issued while the other direction is pending (1..15)
- TURN_CYC, 2, idle cycles inserted on a direction change (0..15)
- TIMEOUT, 4096, max cycles from issue to mem_done before abort (≥2, counter 16 bits)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_req  in  1  write arbiter request; level; held with wr_addr/wr_len stable until wr_ack
- wr_addr  in  30  write burst address
- wr_len  in  8  write burst length (AXI len encoding, passed through)
- wr_ack  out  1  1-cycle pulse: write command issued
- wr_done  out  1  1-cycle pulse: write burst finished or aborted
- rd_req  in  1  read arbiter request; same rules as wr_req
- rd_addr  in  30  read burst address
- rd_len  in  8  read burst length
- rd_ack  out  1  1-cycle pulse: read command issued
- rd_done  out  1  1-cycle pulse: read burst finished or aborted
- mem_start  out  1  1-cycle command strobe to the AXI master
- mem_wr  out  1  direction of the current command (1 = write, 0 = read)
- mem_addr  out  30  registered command address
- mem_len  out  8  registered command length
- mem_done  in  1  AXI master burst-complete pulse
- timeout_err  out  1  sticky; set on watchdog abort

Behaviour:
- Reset values: all outputs 0. Internal: state=IDLE, last_dir=WR, streak=0, timers=0. A reset mid-burst abandons the burst with no done pulse.
- State machine states: IDLE, TURN, ISSUE, BUSY. All outputs are registered.
- IDLE, neither request: stay in IDLE.
- IDLE, exactly one request: that direction is selected.
- IDLE, both requests: select last_dir if streak < MAX_STREAK, otherwise the opposite direction.
- On selection, latch dir, addr and len.
  - If dir ≠ last_dir and TURN_CYC > 0: go to TURN.
  - Otherwise: go to ISSUE.
- TURN: count TURN_CYC cycles, then go to ISSUE. Requests are not re-evaluated; the latched selection stands.
- ISSUE (one cycle):
  - mem_start=1, mem_wr/mem_addr/mem_len = latched values.
  - Matching ack = 1 in the same cycle.
  - Update last_dir. streak = same direction ? min(streak+1, 15) : 1.
  - Go to BUSY.
- Latency: request seen in IDLE at edge N gives mem_start high in cycle N+1 with no turnaround, or N+1+TURN_CYC with turnaround.
- mem_addr and mem_len hold their values until the next ISSUE. mem_wr holds until the next ISSUE.
- BUSY:
  - Watchdog increments each cycle.
  - mem_done: matching done pulse next cycle, then IDLE.
  - Watchdog reaches TIMEOUT: matching done pulse next cycle, timeout_err=1, then IDLE.
- mem_done outside BUSY is ignored (no pulse, no state change).
- mem_done in the same cycle as the watchdog expiring: treat as normal completion; timeout_err is not set.
- Back-to-back: the done cycle lands in IDLE. A new ISSUE occurs no earlier than 2 cycles after the mem_done cycle.
- Requesters may drop a request before ack; the request is re-sampled only in IDLE. A request dropped after selection is still issued.
- timeout_err clears only on rst.

Test Plan:
- Single write: wr_req=1, wr_addr=0x100, wr_len=15 in IDLE → next cycle mem_start=1, mem_wr=1, mem_addr=0x100, mem_len=15, wr_ack=1. Drive mem_done 20 cycles later → wr_done pulses 1 cycle after, back to IDLE.
- Streak cap: MAX_STREAK=4, TURN_CYC=2, wr_req and rd_req both held high, mem_done 5 cycles after each issue → sequence W,W,W,W,R,R,R,R,W. Each W↔R switch shows exactly 2 idle cycles before mem_start.
- Turnaround 0: TURN_CYC=0, alternating single requests R then W → no TURN state; W mem_start exactly 2 cycles after R's mem_done.
- Watchdog: TIMEOUT=16, issue read, never assert mem_done → rd_done pulses at cycle 17 after issue, timeout_err=1 and stays high. A following write still issues normally.
- Stray and simultaneous done: mem_done pulsed in IDLE → no done output. mem_done on the same cycle the watchdog expires → rd_done pulses, timeout_err stays 0.
- Reset mid-burst: rst during BUSY(write) → next cycle all outputs 0, no wr_done. Post-reset, both requests high → write issued first.
